// File: rtl/cplx_seq_pkg.sv
// rtl/cplx_seq_pkg.sv - shared types and sizing helpers for the complex sum sequencer
package cplx_seq_pkg;

    // ACC: accepting beats; DONE: result presented, waiting for downstream.
    typedef enum logic {
        ACC  = 1'b0,
        DONE = 1'b1
    } state_t;

    // Accumulator width: sign + integer + fraction bits plus guard bits.
    function automatic int acc_w(input int qi, input int qf, input int g);
        return qi + qf + 1 + g;
    endfunction

    // Two terms per beat, so an odd term count needs one half-used beat.
    function automatic int beats(input int n);
        return (n + 1) / 2;
    endfunction

    function automatic int sat_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int sat_min(input int w);
        return -(1 << (w - 1));
    endfunction

endpackage

// File: rtl/cplx_add3_sat.sv
// rtl/cplx_add3_sat.sv - combinational 3-input complex adder with saturation
//
// Purpose: o_sum = sat(i_acc + sext(i_a) + sext(i_b)) per component.
// Ports:
//   i_acc_re/i_acc_im  ACC_W  running accumulator (signed)
//   i_a_re/i_a_im      IN_W   lane A term (signed)
//   i_b_re/i_b_im      IN_W   lane B term (signed)
//   o_sum_re/o_sum_im  ACC_W  saturated sum
//   o_sat_re/o_sat_im  1      component was clamped
module cplx_add3_sat
    import cplx_seq_pkg::*;
#(
    parameter int IN_W  = 7,
    parameter int ACC_W = 11
) (
    input  logic [ACC_W-1:0] i_acc_re,
    input  logic [ACC_W-1:0] i_acc_im,
    input  logic [IN_W-1:0]  i_a_re,
    input  logic [IN_W-1:0]  i_a_im,
    input  logic [IN_W-1:0]  i_b_re,
    input  logic [IN_W-1:0]  i_b_im,
    output logic [ACC_W-1:0] o_sum_re,
    output logic [ACC_W-1:0] o_sum_im,
    output logic             o_sat_re,
    output logic             o_sat_im
);

    // Two extra bits hold acc + a + b exactly: |a|,|b| <= 2^(ACC_W-1) each
    // because ACC_W >= IN_W, so the full sum stays below 2^(ACC_W+1).
    localparam int FULL_W = ACC_W + 2;
    localparam int EXT_A  = FULL_W - IN_W;
    localparam logic [ACC_W-1:0] W_MAX = ACC_W'(sat_max(ACC_W));
    localparam logic [ACC_W-1:0] W_MIN = ACC_W'(sat_min(ACC_W));

    logic [FULL_W-1:0] w_full_re;
    logic [FULL_W-1:0] w_full_im;

    assign w_full_re = {{2{i_acc_re[ACC_W-1]}}, i_acc_re}
                     + {{EXT_A{i_a_re[IN_W-1]}}, i_a_re}
                     + {{EXT_A{i_b_re[IN_W-1]}}, i_b_re};
    assign w_full_im = {{2{i_acc_im[ACC_W-1]}}, i_acc_im}
                     + {{EXT_A{i_a_im[IN_W-1]}}, i_a_im}
                     + {{EXT_A{i_b_im[IN_W-1]}}, i_b_im};

    // Returns {clamped, value}. The sum fits ACC_W bits only when the top
    // three bits agree; otherwise the true sign (MSB) picks the rail.
    function automatic logic [ACC_W:0] clamp(input logic [FULL_W-1:0] v);
        logic fits;
        fits = (v[FULL_W-1] == v[ACC_W]) && (v[ACC_W] == v[ACC_W-1]);
        if (fits) begin
            return {1'b0, v[ACC_W-1:0]};
        end else if (v[FULL_W-1]) begin
            return {1'b1, W_MIN};
        end else begin
            return {1'b1, W_MAX};
        end
    endfunction

    assign {o_sat_re, o_sum_re} = clamp(w_full_re);
    assign {o_sat_im, o_sum_im} = clamp(w_full_im);

endmodule

// File: rtl/cplx_sum_sequencer.sv
// rtl/cplx_sum_sequencer.sv - reduces N_TERMS complex terms, two per beat, into one saturated result
//
// Purpose: accumulates lane A + lane B onto a running complex sum each
// accepted beat; after ceil(N_TERMS/2) beats the result is presented on
// the output side with a sticky overflow flag.
// Ports:
//   i_clk, i_rst_n                     clock, async active-low reset
//   i_flush                            drop the partial sum (ignored in DONE)
//   i_in_valid / o_in_ready            beat handshake
//   i_in_a_Re/Im, i_in_b_Re/Im         QI+QF+1 signed lane terms
//   o_out_valid / i_out_ready          result handshake
//   o_out_Re/Im                        ACC_W signed result, LSB = 2^-QF
//   o_out_overflow                     saturation anywhere in this result
module cplx_sum_sequencer
    import cplx_seq_pkg::*;
#(
    parameter int QI        = 3,
    parameter int QF        = 3,
    parameter int N_TERMS   = 9,
    parameter int ACC_GUARD = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_flush,
    input  logic                      i_in_valid,
    output logic                      o_in_ready,
    input  logic [QI+QF:0]            i_in_a_Re,
    input  logic [QI+QF:0]            i_in_a_Im,
    input  logic [QI+QF:0]            i_in_b_Re,
    input  logic [QI+QF:0]            i_in_b_Im,
    output logic                      o_out_valid,
    input  logic                      i_out_ready,
    output logic [QI+QF+ACC_GUARD:0]  o_out_Re,
    output logic [QI+QF+ACC_GUARD:0]  o_out_Im,
    output logic                      o_out_overflow
);

    localparam int IN_W  = QI + QF + 1;
    localparam int ACC_W = acc_w(QI, QF, ACC_GUARD);
    localparam int NB    = beats(N_TERMS);
    localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NB - 1);
    localparam bit ODD_TERMS = (N_TERMS % 2) == 1;

    state_t             r_state;
    logic [ACC_W-1:0]   r_acc_re;
    logic [ACC_W-1:0]   r_acc_im;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf;
    logic [ACC_W-1:0]   r_out_re;
    logic [ACC_W-1:0]   r_out_im;
    logic               r_out_ovf;

    logic               w_last;
    logic               w_accept;
    logic [IN_W-1:0]    w_b_re;
    logic [IN_W-1:0]    w_b_im;
    logic [ACC_W-1:0]   w_sum_re;
    logic [ACC_W-1:0]   w_sum_im;
    logic               w_sat_re;
    logic               w_sat_im;
    logic               w_ovf_next;

    assign o_in_ready  = (r_state == ACC) && !i_flush;
    assign o_out_valid = (r_state == DONE);
    assign o_out_Re       = r_out_re;
    assign o_out_Im       = r_out_im;
    assign o_out_overflow = r_out_ovf;

    assign w_last   = (r_cnt == LAST_BEAT);
    assign w_accept = i_in_valid && o_in_ready;

    // With an odd term count the last beat carries only one real term.
    assign w_b_re = (ODD_TERMS && w_last) ? '0 : i_in_b_Re;
    assign w_b_im = (ODD_TERMS && w_last) ? '0 : i_in_b_Im;

    assign w_ovf_next = r_ovf | w_sat_re | w_sat_im;

    cplx_add3_sat #(
        .IN_W  (IN_W),
        .ACC_W (ACC_W)
    ) u_add3 (
        .i_acc_re (r_acc_re),
        .i_acc_im (r_acc_im),
        .i_a_re   (i_in_a_Re),
        .i_a_im   (i_in_a_Im),
        .i_b_re   (w_b_re),
        .i_b_im   (w_b_im),
        .o_sum_re (w_sum_re),
        .o_sum_im (w_sum_im),
        .o_sat_re (w_sat_re),
        .o_sat_im (w_sat_im)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ACC;
            r_acc_re  <= '0;
            r_acc_im  <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            r_out_re  <= '0;
            r_out_im  <= '0;
            r_out_ovf <= 1'b0;
        end else begin
            case (r_state)
                ACC: begin
                    if (i_flush) begin
                        r_acc_re <= '0;
                        r_acc_im <= '0;
                        r_cnt    <= '0;
                        r_ovf    <= 1'b0;
                    end else if (w_accept) begin
                        if (w_last) begin
                            // Final sum bypasses the accumulator straight
                            // into the output registers.
                            r_out_re  <= w_sum_re;
                            r_out_im  <= w_sum_im;
                            r_out_ovf <= w_ovf_next;
                            r_state   <= DONE;
                            r_acc_re  <= '0;
                            r_acc_im  <= '0;
                            r_cnt     <= '0;
                            r_ovf     <= 1'b0;
                        end else begin
                            r_acc_re <= w_sum_re;
                            r_acc_im <= w_sum_im;
                            r_ovf    <= w_ovf_next;
                            r_cnt    <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (i_out_ready) begin
                        r_state <= ACC;
                    end
                end
                default: begin
                    r_state <= ACC;
                end
            endcase
        end
    end

endmodule
